// File: rtl/gamepad_pmod_receiver.sv
// rtl/gamepad_pmod_receiver.sv - Gamepad Pmod serial receiver with presence detect and link-loss timeout (option macro: GAMEPAD_PRESS_EVT_EN)
module gamepad_pmod_receiver #(
    parameter int SHIFT_BITS     = 24,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pmod_data,
    input  logic        pmod_clk,
    input  logic        pmod_latch,
    output logic [11:0] buttons,
    output logic        present,
    output logic        valid
`ifdef GAMEPAD_PRESS_EVT_EN
    ,
    output logic [11:0] press_evt
`endif
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

    // Synchroniser chains; clk and latch carry an extra history stage for edge detection
    logic data_meta_q, data_meta_d, data_sync_q, data_sync_d;
    logic clk_meta_q, clk_meta_d, clk_sync_q, clk_sync_d, clk_hist_q, clk_hist_d;
    logic latch_meta_q, latch_meta_d, latch_sync_q, latch_sync_d, latch_hist_q, latch_hist_d;

    logic [SHIFT_BITS-1:0] shreg_q, shreg_d;
    logic [TW-1:0]         tcnt_q, tcnt_d;
    logic [11:0]           buttons_q, buttons_d;
    logic                  present_q, present_d;
    logic                  valid_q, valid_d;
`ifdef GAMEPAD_PRESS_EVT_EN
    logic [11:0]           press_evt_q, press_evt_d;
`endif

    logic        clk_rise;
    logic        latch_rise;
    logic [11:0] word;
    logic [11:0] new_buttons;
    logic        timeout_hit;

    // Next-state logic: shift, capture (on pre-shift shreg), and saturating link timeout
    always_comb begin
        data_meta_d  = pmod_data;
        data_sync_d  = data_meta_q;
        clk_meta_d   = pmod_clk;
        clk_sync_d   = clk_meta_q;
        clk_hist_d   = clk_sync_q;
        latch_meta_d = pmod_latch;
        latch_sync_d = latch_meta_q;
        latch_hist_d = latch_sync_q;

        clk_rise   = clk_sync_q & ~clk_hist_q;
        latch_rise = latch_sync_q & ~latch_hist_q;

        // All-ones is what an unconnected (pulled-up) line shifts in
        word        = shreg_q[11:0];
        new_buttons = (&word) ? 12'h000 : word;

        shreg_d = clk_rise ? {shreg_q[SHIFT_BITS-2:0], data_sync_q} : shreg_q;

        if (latch_rise) begin
            tcnt_d = '0;
        end else if (tcnt_q == TMAX) begin
            tcnt_d = tcnt_q;
        end else begin
            tcnt_d = tcnt_q + TW'(1);
        end
        timeout_hit = !latch_rise && (tcnt_q != TMAX) && (tcnt_d == TMAX);

        buttons_d = buttons_q;
        present_d = present_q;
        valid_d   = 1'b0;
        if (latch_rise) begin
            buttons_d = new_buttons;
            present_d = ~(&word);
            valid_d   = 1'b1;
        end else if (timeout_hit) begin
            buttons_d = 12'h000;
            present_d = 1'b0;
        end

`ifdef GAMEPAD_PRESS_EVT_EN
        // Compared against the register, which reads 0 after a timeout clear
        press_evt_d = latch_rise ? (new_buttons & ~buttons_q) : 12'h000;
`endif
    end

    // State register with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (reset) begin
            data_meta_q  <= 1'b0;
            data_sync_q  <= 1'b0;
            clk_meta_q   <= 1'b0;
            clk_sync_q   <= 1'b0;
            clk_hist_q   <= 1'b0;
            latch_meta_q <= 1'b0;
            latch_sync_q <= 1'b0;
            latch_hist_q <= 1'b0;
            shreg_q      <= '0;
            tcnt_q       <= '0;
            buttons_q    <= 12'h000;
            present_q    <= 1'b0;
            valid_q      <= 1'b0;
`ifdef GAMEPAD_PRESS_EVT_EN
            press_evt_q  <= 12'h000;
`endif
        end else begin
            data_meta_q  <= data_meta_d;
            data_sync_q  <= data_sync_d;
            clk_meta_q   <= clk_meta_d;
            clk_sync_q   <= clk_sync_d;
            clk_hist_q   <= clk_hist_d;
            latch_meta_q <= latch_meta_d;
            latch_sync_q <= latch_sync_d;
            latch_hist_q <= latch_hist_d;
            shreg_q      <= shreg_d;
            tcnt_q       <= tcnt_d;
            buttons_q    <= buttons_d;
            present_q    <= present_d;
            valid_q      <= valid_d;
`ifdef GAMEPAD_PRESS_EVT_EN
            press_evt_q  <= press_evt_d;
`endif
        end
    end

    assign buttons = buttons_q;
    assign present = present_q;
    assign valid   = valid_q;
`ifdef GAMEPAD_PRESS_EVT_EN
    assign press_evt = press_evt_q;
`endif

endmodule

// File: tb/tb_gamepad_pmod_receiver.sv
// tb/tb_gamepad_pmod_receiver.sv - Self-checking bench for gamepad_pmod_receiver
module tb_gamepad_pmod_receiver;

    logic        clk;
    logic        reset;
    logic        pmod_data;
    logic        pmod_clk;
    logic        pmod_latch;
    logic [11:0] buttons;
    logic        present;
    logic        valid;
`ifdef GAMEPAD_PRESS_EVT_EN
    logic [11:0] press_evt;
`endif

    gamepad_pmod_receiver #(.SHIFT_BITS(24), .TIMEOUT_CYCLES(100)) dut (
        .clk       (clk),
        .reset     (reset),
        .pmod_data (pmod_data),
        .pmod_clk  (pmod_clk),
        .pmod_latch(pmod_latch),
        .buttons   (buttons),
        .present   (present),
        .valid     (valid)
`ifdef GAMEPAD_PRESS_EVT_EN
        ,
        .press_evt (press_evt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [11:0] b;
        logic        p;
    } exp_t;

    typedef struct {
        logic [23:0] frame;
        logic [11:0] exp_b;
        logic        exp_p;
    } vec_t;

    exp_t        sb[$];
    vec_t        vecs[8];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          latch_cyc = 0;
    int          last_valid_cyc = 0;
    int          n_valid = 0;
    int          hp = 4;
    logic [11:0] last_press = 12'h000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock step; outputs sampled on the falling edge and valid pulses scored here
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (valid === 1'b1) begin
            n_valid++;
            last_valid_cyc = cyc;
`ifdef GAMEPAD_PRESS_EVT_EN
            last_press = press_evt;
`endif
            if (sb.size() == 0) begin
                chk("unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("buttons", {20'd0, buttons}, {20'd0, e.b});
                chk("present", {31'd0, present}, {31'd0, e.p});
                chk("latency_3_to_4", {31'd0, ((cyc - latch_cyc) >= 3) && ((cyc - latch_cyc) <= 4)}, 32'd1);
            end
        end
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_bit(input logic b);
        pmod_data = b;
        wait_ticks(hp);
        pmod_clk = 1'b1;
        wait_ticks(hp);
        pmod_clk = 1'b0;
    endtask

    task automatic send_frame(input logic [23:0] f, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) send_bit(f[i]);
    endtask

    task automatic latch_pulse();
        pmod_latch = 1'b1;
        latch_cyc  = cyc;
        wait_ticks(hp);
        pmod_latch = 1'b0;
        wait_ticks(hp);
    endtask

    task automatic push(input logic [11:0] b, input logic p);
        exp_t e;
        e.b = b;
        e.p = p;
        sb.push_back(e);
    endtask

    initial begin
        int n;
        int v0;

        vecs[0] = '{24'hABC100, 12'h100, 1'b1};
        vecs[1] = '{24'h000FFF, 12'h000, 1'b0};
        vecs[2] = '{24'h123800, 12'h800, 1'b1};
        vecs[3] = '{24'hFFF001, 12'h001, 1'b1};
        vecs[4] = '{24'h000000, 12'h000, 1'b1};
        vecs[5] = '{24'h555AAA, 12'hAAA, 1'b1};
        vecs[6] = '{24'hFFFFFE, 12'hFFE, 1'b1};
        vecs[7] = '{24'h0F0FFF, 12'h000, 1'b0};

        reset      = 1'b1;
        pmod_data  = 1'b0;
        pmod_clk   = 1'b0;
        pmod_latch = 1'b0;

        // Reset state and idle pins
        wait_ticks(2);
        chk("reset_buttons", {20'd0, buttons}, 32'd0);
        chk("reset_present", {31'd0, present}, 32'd0);
        chk("reset_valid", {31'd0, valid}, 32'd0);
`ifdef GAMEPAD_PRESS_EVT_EN
        chk("reset_press_evt", {20'd0, press_evt}, 32'd0);
`endif
        reset = 1'b0;
        wait_ticks(10);
        chk("idle_no_valid", n_valid, 32'd0);

        // Table-driven frames
        for (int k = 0; k < 8; k++) begin
            send_frame(vecs[k].frame, 24);
            push(vecs[k].exp_b, vecs[k].exp_p);
            latch_pulse();
            chk("valid_seen", sb.size(), 32'd0);
            sb.delete();
        end

        // Clock and latch rise together: capture sees pre-shift contents
        send_frame(24'h0000A5, 24);
        pmod_data = 1'b1;
        wait_ticks(hp);
        pmod_clk   = 1'b1;
        pmod_latch = 1'b1;
        latch_cyc  = cyc;
        push(12'h0A5, 1'b1);
        wait_ticks(hp);
        pmod_clk   = 1'b0;
        pmod_latch = 1'b0;
        pmod_data  = 1'b0;
        wait_ticks(hp);
        chk("simul_capture_seen", sb.size(), 32'd0);
        sb.delete();
        push(12'h14B, 1'b1);
        latch_pulse();
        chk("simul_shift_seen", sb.size(), 32'd0);
        sb.delete();

        // Link-loss timeout after a capture
        send_frame(24'h000010, 24);
        push(12'h010, 1'b1);
        latch_pulse();
        chk("timeout_capture_seen", sb.size(), 32'd0);
        sb.delete();
        v0 = n_valid;
        n = 0;
        while (present === 1'b1 && n < 300) begin
            tick();
            n++;
        end
        chk("timeout_cycles", cyc - last_valid_cyc, 32'd100);
        chk("timeout_present", {31'd0, present}, 32'd0);
        chk("timeout_buttons", {20'd0, buttons}, 32'd0);
        wait_ticks(5);
        chk("timeout_no_valid", n_valid - v0, 32'd0);
        chk("timeout_hold_present", {31'd0, present}, 32'd0);

`ifdef GAMEPAD_PRESS_EVT_EN
        // Press events against the previous register value; short frames beat the timeout
        hp = 3;
        send_frame(24'h000010, 12);
        push(12'h010, 1'b1);
        latch_pulse();
        send_frame(24'h000030, 12);
        push(12'h030, 1'b1);
        latch_pulse();
        chk("press_new_bit", {20'd0, last_press}, 32'h020);
        send_frame(24'h000030, 12);
        push(12'h030, 1'b1);
        latch_pulse();
        chk("press_repeat", {20'd0, last_press}, 32'h000);
        chk("press_drained", sb.size(), 32'd0);
        hp = 4;
`endif

        chk("final_sb_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
